// File: rtl/serial_rx_fwdclk_pkg.sv
// Shared definitions for the forwarded-clock serial receiver.
// Holds the receive FSM state type, the data width and the line levels
// of the start and stop bits, so the top and the bench agree on them.
package serial_rx_fwdclk_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/serial_rx_fwdclk_sync_edge_det.sv
// Two-flop synchronizer with registered rising-edge detection on a strobe
// lane, plus plain synchronization of DATA_W companion data lanes that
// travel with the strobe.
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset; all sync flops go to 1 (idle)
//   strobe     asynchronous strobe (forwarded serial clock)
//   data       asynchronous data lanes, captured alongside the strobe
//   rise       one-cycle pulse, registered, for each strobe rising edge
//   data_sync  data lanes as seen in the same cycle the edge was detected
module sync_edge_det #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  output logic              rise,
  output logic [DATA_W-1:0] data_sync
);

  logic              strobe_s1;
  logic              strobe_s2;
  logic              strobe_prev;
  logic [DATA_W-1:0] data_s1;
  logic [DATA_W-1:0] data_s2;

  // Data lanes go through the same two-flop depth as the strobe so that the
  // value captured with the edge is the one present at the strobe edge.
  // The edge and its data are registered together, so the consumer sees
  // them one cycle after detection, in step with each other.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      strobe_s1   <= 1'b1;
      strobe_s2   <= 1'b1;
      strobe_prev <= 1'b1;
      data_s1     <= '1;
      data_s2     <= '1;
      rise        <= 1'b0;
      data_sync   <= '1;
    end else begin
      strobe_s1   <= strobe;
      strobe_s2   <= strobe_s1;
      strobe_prev <= strobe_s2;
      data_s1     <= data;
      data_s2     <= data_s1;
      rise        <= strobe_s2 & ~strobe_prev;
      data_sync   <= data_s2;
    end
  end

endmodule

// File: rtl/serial_rx_fwdclk.sv
// Serial receiver for a transmitter that forwards its bit clock.
// Frame: start 0, 8 data bits LSB first, parity, stop 1; idle line is 1.
// Ports:
//   Clock     system clock, rising edge
//   Resetn    synchronous active-low reset
//   SClk      forwarded serial clock, asynchronous to Clock
//   SData     serial data, valid at SClk rising edge
//   PDout     last accepted byte (also bytes with a parity error)
//   Pready    one-cycle pulse when PDout is loaded
//   ParError  parity status of the last accepted frame
//   FrameErr  one-cycle pulse when a frame is aborted (bad stop / timeout)
module serial_rx_fwdclk
  import serial_rx_fwdclk_pkg::*;
#(
  parameter int EVEN_PARITY = 1,
  parameter int TIMEOUT     = 1023
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       SClk,
  input  logic       SData,
  output logic [7:0] PDout,
  output logic       Pready,
  output logic       ParError,
  output logic       FrameErr
);

  localparam int           TO_W       = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic         PAR_EXPECT = (EVEN_PARITY != 0) ? 1'b0 : 1'b1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  logic                  sclk_rise;
  logic                  sdata_bit;
  rx_state_t             state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  par_err;
  logic [TO_W-1:0]       to_cnt;

  sync_edge_det #(
    .DATA_W (1)
  ) u_sync (
    .clk       (Clock),
    .resetn    (Resetn),
    .strobe    (SClk),
    .data      (SData),
    .rise      (sclk_rise),
    .data_sync (sdata_bit)
  );

  // Receive FSM. The timeout counter restarts on every SClk edge and only
  // runs while a frame is in progress; it saturates so a stalled line can
  // never wrap it back into a false "recent edge" state.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
      to_cnt    <= '0;
      PDout     <= '0;
      Pready    <= 1'b0;
      ParError  <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      Pready   <= 1'b0;
      FrameErr <= 1'b0;

      if (state == IDLE || sclk_rise) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state != IDLE && !sclk_rise && to_cnt == TO_MAX) begin
        FrameErr <= 1'b1;
        state    <= IDLE;
      end else if (sclk_rise) begin
        case (state)
          IDLE: begin
            if (sdata_bit == START_BIT) begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            shift_reg[bit_cnt] <= sdata_bit;
            bit_cnt            <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_err <= ((^shift_reg) ^ sdata_bit) != PAR_EXPECT;
            state   <= STOP;
          end
          STOP: begin
            // A parity error still delivers the byte; only a bad stop bit
            // discards it.
            if (sdata_bit == STOP_BIT) begin
              PDout    <= shift_reg;
              ParError <= par_err;
              Pready   <= 1'b1;
            end else begin
              FrameErr <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_fwdclk.sv
// Self-checking bench for serial_rx_fwdclk. Frames are driven with an
// 8-cycle SClk; each expected Pready/FrameErr event is queued when its
// triggering SClk edge is driven and checked by a monitor when it appears.
module tb_serial_rx_fwdclk;

  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic       SClk   = 1'b0;
  logic       SData  = 1'b1;
  logic [7:0] PDout;
  logic       Pready;
  logic       ParError;
  logic       FrameErr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic       par;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_pd  = 8'h00;
  logic       model_par = 1'b0;

  serial_rx_fwdclk #(
    .EVEN_PARITY (1),
    .TIMEOUT     (1023)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .SClk     (SClk),
    .SData    (SData),
    .PDout    (PDout),
    .Pready   (Pready),
    .ParError (ParError),
    .FrameErr (FrameErr)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc++;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (Pready === 1'b1 || FrameErr === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse: Pready=%b FrameErr=%b PDout=%h, required no pulse",
                 Pready, FrameErr, PDout);
      end else begin
        e = sb.pop_front();
        if (FrameErr !== e.is_err || Pready !== !e.is_err) begin
          failures++;
          $display("[TB] FAIL pulse_kind: Pready=%b FrameErr=%b, required FrameErr=%b",
                   Pready, FrameErr, e.is_err);
        end
        checks++;
        if (PDout !== e.data) begin
          failures++;
          $display("[TB] FAIL pdout: got %h, required %h", PDout, e.data);
        end
        checks++;
        if (ParError !== e.par) begin
          failures++;
          $display("[TB] FAIL parerror: got %b, required %b", ParError, e.par);
        end
        if (e.due != 0) begin
          checks++;
          if (cyc != e.due) begin
            failures++;
            $display("[TB] FAIL latency: pulse at cycle %0d, required cycle %0d", cyc, e.due);
          end
        end
      end
    end
  end

  // Drives the first nbits bits of a frame; queues the result at the stop edge.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int nbits);
    logic [10:0] bits;
    logic        perr;
    exp_t        e;
    bits = {stop, pbit, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      SData = bits[i];
      repeat (4) begin @(posedge Clock); #1; end
      if (i == 10) begin
        perr = (^d) ^ pbit;
        if (stop) begin
          model_pd  = d;
          model_par = perr;
          e = '{is_err: 1'b0, data: d, par: perr, due: cyc + 4};
        end else begin
          e = '{is_err: 1'b1, data: model_pd, par: model_par, due: cyc + 4};
        end
        sb.push_back(e);
      end
      SClk = 1'b1;
      repeat (4) begin @(posedge Clock); #1; end
      SClk = 1'b0;
    end
    SData = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    wait_cycles(3);
    checks++;
    if (PDout !== 8'h00 || Pready !== 1'b0 || ParError !== 1'b0 || FrameErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: PDout=%h Pready=%b ParError=%b FrameErr=%b, required 00 0 0 0",
               PDout, Pready, ParError, FrameErr);
    end
    checks++;
    if (dut.state !== serial_rx_fwdclk_pkg::IDLE) begin
      failures++;
      $display("[TB] FAIL reset_state: got %0d, required IDLE", dut.state);
    end
    Resetn = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_idle_noise();
    SData = 1'b1;
    for (int i = 0; i < 3; i++) begin
      SClk = 1'b1; wait_cycles(4);
      SClk = 1'b0; wait_cycles(4);
    end
    wait_cycles(6);
    checks++;
    if (PDout !== model_pd) begin
      failures++;
      $display("[TB] FAIL idle_noise: PDout=%h, required %h", PDout, model_pd);
    end
  endtask

  task automatic test_good_byte();
    send_frame(8'hA5, 1'b0, 1'b1, 11);
    wait_cycles(8);
  endtask

  task automatic test_parity_error();
    send_frame(8'h01, 1'b0, 1'b1, 11);
    wait_cycles(8);
    send_frame(8'h03, 1'b0, 1'b1, 11);
    wait_cycles(8);
  endtask

  task automatic test_bad_stop();
    send_frame(8'h3C, 1'b0, 1'b0, 11);
    wait_cycles(8);
  endtask

  task automatic test_timeout();
    exp_t e;
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    e = '{is_err: 1'b1, data: model_pd, par: model_par, due: 0};
    sb.push_back(e);
    wait_cycles(1100);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL timeout_pulse: %0d events pending, required 0", sb.size());
    end
    checks++;
    if (dut.state !== serial_rx_fwdclk_pkg::IDLE) begin
      failures++;
      $display("[TB] FAIL timeout_state: got %0d, required IDLE", dut.state);
    end
    send_frame(8'h7E, 1'b0, 1'b1, 11);
    wait_cycles(8);
  endtask

  task automatic test_mid_frame_reset();
    send_frame(8'hC3, 1'b0, 1'b1, 6);
    wait_cycles(2);
    Resetn = 1'b0;
    wait_cycles(2);
    Resetn    = 1'b1;
    model_pd  = 8'h00;
    model_par = 1'b0;
    wait_cycles(20);
    checks++;
    if (PDout !== 8'h00 || ParError !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: PDout=%h ParError=%b, required 00 0", PDout, ParError);
    end
    send_frame(8'hFF, 1'b0, 1'b1, 11);
    wait_cycles(8);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, 1'b0, 1'b1, 11);
    send_frame(8'hAA, 1'b0, 1'b1, 11);
    wait_cycles(8);
    checks++;
    if (PDout !== 8'hAA) begin
      failures++;
      $display("[TB] FAIL back_to_back_final: PDout=%h, required aa", PDout);
    end
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    test_good_byte();
    test_parity_error();
    test_bad_stop();
    test_timeout();
    test_mid_frame_reset();
    test_back_to_back();
    wait_cycles(20);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL missing_events: %0d events pending, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/serial_rx_fwdclk.md
SERIAL_RX_FWDCLK -- requirements
Module: serial_rx_fwdclk

Interface
REQ-001 Parameter EVEN_PARITY, default 1, meaning: 1 = even parity expected, 0 = odd.
REQ-002 Parameter TIMEOUT, default 1023, meaning: max Clock cycles between SClk rising edges inside a frame.
REQ-003 Clock  input  1  system clock, all logic on rising edge.
REQ-004 Resetn  input  1  reset; synchronous, active-low.
REQ-005 SClk  input  1  forwarded serial clock from the transmitter's clockout, asynchronous to Clock.
REQ-006 SData  input  1  serial data from the transmitter, valid at SClk rising edge.
REQ-007 PDout  output  8  last good received byte.
REQ-008 Pready  output  1  one-Clock pulse, new byte on PDout.
REQ-009 ParError  output  1  parity status of the last completed frame.
REQ-010 FrameErr  output  1  one-Clock pulse, frame aborted (bad stop bit or timeout).

Function
REQ-011 Frame SHALL be: start bit 0, 8 data bits LSB first, 1 parity bit, stop bit 1; line idle = 1.
REQ-012 SClk and SData SHALL pass through a 2-flop synchronizer; SClk rising edge SHALL be detected as sync2=1 and previous sync2=0; SData SHALL be sampled from its own sync2 in the detect cycle.
REQ-013 SClk high and low phases SHALL each be at least 3 Clock cycles; shorter phases are outside spec.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on edge with SData=0 -> DATA, bit counter cleared; edge with SData=1 ignored.
REQ-016 DATA: each edge shifts SData into bit[count] (LSB first), count increments; edge on count 7 -> PARITY.
REQ-017 PARITY: on edge, parity error = (XOR of 8 data bits XOR SData) != (EVEN_PARITY ? 0 : 1); -> STOP.
REQ-018 STOP: on edge with SData=1 -> PDout loaded, ParError loaded with the computed error, Pready pulses, -> IDLE.
REQ-019 STOP: on edge with SData=0 -> FrameErr pulses, PDout and ParError unchanged, -> IDLE.
REQ-020 A byte with parity error SHALL still be loaded to PDout with Pready, ParError=1.
REQ-021 Pready/FrameErr SHALL assert exactly 4 Clock cycles after the stop-bit SClk rising edge at the port (2 sync + 1 detect + 1 output register), for exactly 1 cycle.
REQ-022 Timeout counter SHALL clear on every detected edge and count in DATA/PARITY/STOP; reaching TIMEOUT -> FrameErr pulse, -> IDLE, PDout unchanged.
REQ-023 Counter width SHALL be clog2(TIMEOUT+1); it SHALL saturate, never wrap, and stay 0 in IDLE.
REQ-024 Back-to-back frames SHALL be accepted: a start bit on the edge immediately after stop SHALL be received without loss.

Reset
REQ-025 On Resetn=0 at a Clock edge: state IDLE, PDout=0x00, Pready=0, ParError=0, FrameErr=0, counters 0, synchronizer flops 1 (idle level).
REQ-026 Reset mid-frame SHALL discard the partial frame; no Pready or FrameErr SHALL be produced for it.

Structure
REQ-027 Shared package SHALL hold the state enum, DATA_BITS=8 and the frame-bit constants (START=0, STOP=1).
REQ-028 Synchronizer plus edge detector SHALL be one sub-module, sync_edge_det, instantiated for SClk and reused for SData sync.

Verification
REQ-029 Byte 0xA5, EVEN_PARITY=1, parity bit 0, stop 1 -> Pready 1 cycle, PDout=0xA5, ParError=0, FrameErr=0.
REQ-030 Byte 0x01, parity bit 0 (wrong) -> Pready, PDout=0x01, ParError=1; next good byte 0x03 clears ParError to 0.
REQ-031 Byte 0x3C with stop bit 0 -> FrameErr 1 cycle, no Pready, PDout keeps previous value.
REQ-032 SClk stops after 4 data bits for 1024 cycles -> FrameErr pulse, FSM IDLE; following frame 0x7E received correctly.
REQ-033 Resetn low 2 cycles after 5th data bit -> PDout=0x00, no pulses; subsequent frame 0xFF (parity 0) -> PDout=0xFF, ParError=0.
REQ-034 Frames 0x55 then 0xAA back-to-back, SClk period 8 Clock -> two Pready pulses, PDout 0x55 then 0xAA.
